// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle mult/div unit owning HI/LO; define EX_MDU_MADD_EN to enable MADD on MDUOp 7
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi, pend_lo;
  logic [63:0] smul, umul, res;
  logic [31:0] ma, mb, mq, mr, sq, sr, uq, ur;
  logic is_mul, is_div, go;
  always_comb begin
    smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    umul = {32'd0, A} * {32'd0, B};
    ma = A[31] ? -A : A;
    mb = B[31] ? -B : B;
    mq = (mb == '0) ? '0 : ma / mb;
    mr = (mb == '0) ? '0 : ma % mb;
    sq = (A[31] ^ B[31]) ? -mq : mq;
    sr = A[31] ? -mr : mr;
    uq = (B == '0) ? '0 : A / B;
    ur = (B == '0) ? '0 : A % B;
    is_mul = (MDUOp == 3'd1) || (MDUOp == 3'd2);
    is_div = (MDUOp == 3'd3) || (MDUOp == 3'd4);
    res = (MDUOp == 3'd1) ? smul : (MDUOp == 3'd2) ? umul : (MDUOp == 3'd3) ? {sr, sq} : {ur, uq};
`ifdef EX_MDU_MADD_EN
    if (MDUOp == 3'd7) begin
      is_mul = 1'b1;
      res = {HI, LO} + smul;
    end
`endif
    go = Start && (state == IDLE) && (is_mul || (is_div && B != '0));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Busy <= 1'b0;
      cnt <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      HI <= '0;
      LO <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        state <= RUN;
        Busy <= 1'b1;
        cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        {pend_hi, pend_lo} <= res;
      end
      if (MDUOp == 3'd5) HI <= A;
      if (MDUOp == 3'd6) LO <= A;
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= IDLE;
        Busy <= 1'b0;
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed and random scoreboard bench for ex_mdu
module tb_ex_mdu;
  logic clk = 1'b0, reset = 1'b1, Start = 1'b0;
  logic [2:0] MDUOp = 3'd0;
  logic [31:0] A = '0, B = '0;
  logic Busy;
  logic [31:0] HI, LO;
  int compared = 0, mismatched = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int cycles;} exp_t;
  exp_t sboard[$];

  ex_mdu dut (.clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
              .Busy(Busy), .HI(HI), .LO(LO));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    logic [63:0] r;
    exp_t e;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    r = {m_hi, m_lo};
    e.cycles = 0;
    if (op == 3'd1) begin r = 64'(sa * sbv); e.cycles = 5; end
    if (op == 3'd2) begin r = {32'd0, a} * {32'd0, b}; e.cycles = 5; end
    if (op == 3'd3 && b != 0) begin r = {32'(sa % sbv), 32'(sa / sbv)}; e.cycles = 10; end
    if (op == 3'd4 && b != 0) begin r = {a % b, a / b}; e.cycles = 10; end
`ifdef EX_MDU_MADD_EN
    if (op == 3'd7) begin r = {m_hi, m_lo} + 64'(sa * sbv); e.cycles = 5; end
`endif
    {e.hi, e.lo} = r;
    return e;
  endfunction

  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    exp_t e;
    int n;
    Start = 1'b1; MDUOp = op; A = a; B = b;
    sboard.push_back(model(op, a, b));
    @(negedge clk);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      chk({tag, " hold_hi"}, HI, m_hi);
      chk({tag, " hold_lo"}, LO, m_lo);
      Start = poke && n == 0;
      MDUOp = (poke && n == 0) ? 3'd6 : 3'd0;
      A = 32'hDEADBEEF;
      n++;
      @(negedge clk);
    end
    Start = 1'b0; MDUOp = 3'd0;
    e = sboard.pop_front();
    chk({tag, " busy_cycles"}, 32'(n), 32'(e.cycles));
    chk({tag, " hi"}, HI, e.hi);
    chk({tag, " lo"}, LO, e.lo);
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    MDUOp = op; A = a;
    @(negedge clk);
    MDUOp = 3'd0;
    if (op == 3'd5) m_hi = a; else m_lo = a;
    chk(op == 3'd5 ? "mthi hi" : "mtlo lo", op == 3'd5 ? HI : LO, a);
    chk("mtx busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    chk("reset busy", 32'(Busy), 32'd0);
    reset = 1'b0;
    issue("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult spec hi", HI, 32'hFFFFFFFF);
    chk("mult spec lo", LO, 32'hFFFFFFFA);
    issue("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu spec hi", HI, 32'd1);
    chk("multu spec lo", LO, 32'hFFFFFFFE);
    issue("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div spec lo", LO, 32'hFFFFFFFD);
    chk("div spec hi", HI, 32'hFFFFFFFF);
    issue("divu0", 3'd4, 32'd7, 32'd0, 1'b0);
    chk("divu0 spec hi", HI, 32'hFFFFFFFF);
    chk("divu0 spec lo", LO, 32'hFFFFFFFD);
    move(3'd5, 32'h12345678);
    issue("mult_mtlo_busy", 3'd1, 32'd3, 32'd4, 1'b1);
    chk("mult_mtlo_busy spec lo", LO, 32'd12);
    issue("div_min", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_min spec lo", LO, 32'h80000000);
    chk("div_min spec hi", HI, 32'd0);
`ifdef EX_MDU_MADD_EN
    move(3'd5, 32'd0);
    move(3'd6, 32'hFFFFFFFF);
    issue("madd", 3'd7, 32'd1, 32'd1, 1'b0);
    chk("madd spec hi", HI, 32'd1);
    chk("madd spec lo", LO, 32'd0);
`else
    issue("op7_reserved", 3'd7, 32'd5, 32'd6, 1'b0);
`endif
    issue("nop", 3'd0, 32'd9, 32'd9, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue($sformatf("rand%0d", i), op, a, b, 1'b0);
    end
    move(3'd5, 32'hA5A5A5A5);
    Start = 1'b1; MDUOp = 3'd4; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    repeat (3) @(negedge clk);
    chk("abort busy before reset", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort hi", HI, 32'd0);
    chk("abort lo", LO, 32'd0);
    chk("abort busy", 32'(Busy), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort late hi", HI, 32'd0);
    chk("abort late lo", LO, 32'd0);
    chk("abort late busy", 32'(Busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
